// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter shared by the I-cache and D-cache controllers.
// Grants one requester per transaction, latches its address/wdata/op, forwards
// the transaction to main memory and routes rdata/resp back to the granted cache.
// Build option: define ARB_ROUND_ROBIN_EN to break ties by alternating grants;
// otherwise ties go to the D-cache (fixed priority).
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // D-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // Main memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  // 1: most recent grant went to the D-cache
  logic                last_d_q, last_d_d;

  logic i_pend, d_pend, pick_d, granted;

  assign i_pend  = i_pmem_read | i_pmem_write;
  assign d_pend  = d_pmem_read | d_pmem_write;
  assign granted = (state_q == StGrantI) | (state_q == StGrantD);

  // Tie-break between simultaneous requesters
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_pend & (~i_pend | ~last_d_q);
`else
    pick_d = d_pend;
`endif
  end

  // Next-state, capture of the granted transaction and grant history
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    last_d_d = last_d_q;
    unique case (state_q)
      StIdle: begin
        if (i_pend | d_pend) begin
          if (pick_d) begin
            state_d  = StGrantD;
            addr_d   = d_pmem_address;
            wdata_d  = d_pmem_wdata;
            write_d  = d_pmem_write; // write wins over read when both are raised
            last_d_d = 1'b1;
          end else begin
            state_d  = StGrantI;
            addr_d   = i_pmem_address;
            wdata_d  = i_pmem_wdata;
            write_d  = i_pmem_write;
            last_d_d = 1'b0;
          end
        end
      end
      StGrantI, StGrantD: begin
        if (mem_resp) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and transaction latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      last_d_q <= last_d_d;
    end
  end

  // Memory-side drive: op drops in the response cycle so memory never sees a second request
  always_comb begin
    mem_read    = granted & ~write_q & ~mem_resp;
    mem_write   = granted & write_q & ~mem_resp;
    mem_address = granted ? addr_q : '0;
    mem_wdata   = granted ? wdata_q : '0;
  end

  // Response routing: only the granted cache ever sees resp/rdata
  always_comb begin
    i_pmem_resp  = (state_q == StGrantI) & mem_resp;
    d_pmem_resp  = (state_q == StGrantD) & mem_resp;
    i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
    d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized scoreboard bench for pmem_arbiter. The stimulus process plays both
// caches and main memory, and predicts which request is served and when from
// the arbitration rules; a monitor compares what the DUT presents.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst_n;
  logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [AW-1:0] i_pmem_address, d_pmem_address, mem_address;
  logic [LW-1:0] i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
  logic          i_pmem_resp, d_pmem_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [LW-1:0] mem_wdata, mem_rdata;

  // Requester drive, index 0 = I-cache, 1 = D-cache
  logic          r_read  [2];
  logic          r_write [2];
  logic [AW-1:0] r_addr  [2];
  logic [LW-1:0] r_wdata [2];

  assign i_pmem_read    = r_read[0];
  assign i_pmem_write   = r_write[0];
  assign i_pmem_address = r_addr[0];
  assign i_pmem_wdata   = r_wdata[0];
  assign d_pmem_read    = r_read[1];
  assign d_pmem_write   = r_write[1];
  assign d_pmem_address = r_addr[1];
  assign d_pmem_wdata   = r_wdata[1];

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_address (i_pmem_address),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            start;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_t;

  typedef struct {
    int            who;
    logic [LW-1:0] rdata;
  } rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_resp[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model of the shared channel
  int owner = -1;  // requester holding the memory port, -1 none
  bit cool  = 1'b0; // one dead cycle after each completion
  int last  = 1;    // most recent grant; D-cache after reset
  int cnt   = 0;    // cycles left before memory responds
  bit busy [2];     // requester has an outstanding request

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cycle of the reference model, called just after each rising edge
  task automatic step(input bit allow);
    bit fin [2];
    int w;
    int op;
    fin[0] = 1'b0;
    fin[1] = 1'b0;
    // What the arbiter did at the edge just passed
    if (owner >= 0) begin
      if (mem_resp) begin
        fin[owner]     = 1'b1;
        busy[owner]    = 1'b0;
        r_read[owner]  = 1'b0;
        r_write[owner] = 1'b0;
        owner          = -1;
        cool           = 1'b1;
      end
    end else if (cool) begin
      cool = 1'b0;
    end else if (busy[0] || busy[1]) begin
      if (busy[0] && busy[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (last == 1) ? 0 : 1;
`else
        w = 1;
`endif
      end else begin
        w = busy[1] ? 1 : 0;
      end
      owner = w;
      last  = w;
      cnt   = $urandom_range(0, 4);
      exp_mem.push_back('{start: cyc, wr: r_write[w], addr: r_addr[w], wdata: r_wdata[w]});
    end
    // Memory behaviour for the coming cycle; rdata is noise unless responding
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    if (owner >= 0) begin
      if (cnt == 0) begin
        mem_resp = 1'b1;
        exp_resp.push_back('{who: owner, rdata: mem_rdata});
      end else begin
        cnt--;
        // Owner changes or drops its inputs mid-grant; must not matter
        if ($urandom_range(0, 2) == 0) begin
          r_addr[owner]  = $urandom;
          r_wdata[owner] = rand_line();
          r_read[owner]  = 1'($urandom_range(0, 1));
          r_write[owner] = 1'($urandom_range(0, 1));
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_resp = 1'b1; // stray completion while no grant is active
    end
    // New requests from idle caches
    for (int k = 0; k < 2; k++) begin
      if (allow && !busy[k] && !fin[k] && $urandom_range(0, 2) == 0) begin
        op         = $urandom_range(0, 3);
        r_read[k]  = (op != 1);
        r_write[k] = (op == 1 || op == 2);
        r_addr[k]  = $urandom & 32'hFFFF_FFE0;
        r_wdata[k] = rand_line();
        busy[k]    = 1'b1;
      end
    end
  endtask

  task automatic run_random(input int ncyc);
    int k;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      step(1'b1);
    end
    k = 0;
    while (!(owner < 0 && !cool && !busy[0] && !busy[1]) && k < 300) begin
      @(posedge clk);
      #1;
      step(1'b0);
      k++;
    end
    chki("drain_done", (owner < 0 && !cool && !busy[0] && !busy[1]) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    chki("exp_mem_left", exp_mem.size(), 0);
    chki("exp_resp_left", exp_resp.size(), 0);
  endtask

  // Monitor: compares the memory-side transaction and cache responses each cycle
  initial begin
    bit   prev_eng;
    bit   has_cur;
    bit   eng;
    mem_t cur;
    rsp_t r;
    prev_eng = 1'b0;
    has_cur  = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_eng = 1'b0;
        has_cur  = 1'b0;
      end else begin
        eng = mem_read | mem_write | i_pmem_resp | d_pmem_resp;
        chk1("rd_wr_exclusive", mem_read & mem_write, 1'b0);
        chk1("resp_exclusive", i_pmem_resp & d_pmem_resp, 1'b0);
        if (eng && !prev_eng) begin
          if (exp_mem.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant_unexpected: got addr %h expected no grant (cycle %0d)",
                     mem_address, cyc);
            has_cur = 1'b0;
          end else begin
            cur     = exp_mem.pop_front();
            has_cur = 1'b1;
            chki("grant_cycle", cyc, cur.start);
          end
        end
        if (eng && has_cur) begin
          chkw("mem_address", LW'(mem_address), LW'(cur.addr));
          chkw("mem_wdata", mem_wdata, cur.wdata);
          if (mem_read | mem_write) chk1("mem_write_op", mem_write, cur.wr);
        end
        if (!eng) begin
          chkw("idle_address", LW'(mem_address), '0);
          chkw("idle_wdata", mem_wdata, '0);
        end
        if (i_pmem_resp | d_pmem_resp) begin
          if (exp_resp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got i=%b d=%b expected none (cycle %0d)",
                     i_pmem_resp, d_pmem_resp, cyc);
          end else begin
            r = exp_resp.pop_front();
            chki("resp_who", d_pmem_resp ? 1 : 0, r.who);
            chkw("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, r.rdata);
            chkw("other_rdata", d_pmem_resp ? i_pmem_rdata : d_pmem_rdata, '0);
          end
        end else begin
          chkw("i_rdata_quiet", i_pmem_rdata, '0);
          chkw("d_rdata_quiet", d_pmem_rdata, '0);
        end
        prev_eng = eng;
      end
    end
  end

  // Stimulus
  initial begin
    for (int k = 0; k < 2; k++) begin
      r_read[k]  = 1'b0;
      r_write[k] = 1'b0;
      r_addr[k]  = '0;
      r_wdata[k] = '0;
      busy[k]    = 1'b0;
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chkw("rst_mem_address", LW'(mem_address), '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    chk1("rst_i_resp", i_pmem_resp, 1'b0);
    chk1("rst_d_resp", d_pmem_resp, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_random(3000);

    // Reset in the middle of an I-cache grant
    mon_en       = 1'b0;
    r_read[0]    = 1'b1;
    r_addr[0]    = 32'h0000_1000;
    r_wdata[0]   = rand_line();
    @(posedge clk);
    #1;
    chk1("pre_rst_mem_read", mem_read, 1'b1);
    chkw("pre_rst_address", LW'(mem_address), LW'(32'h0000_1000));
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_mem_read", mem_read, 1'b0);
    chkw("async_rst_address", LW'(mem_address), '0);
    r_read[0] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_resp  = 1'b1;
    mem_rdata = rand_line();
    #1;
    chk1("late_resp_i", i_pmem_resp, 1'b0);
    chk1("late_resp_d", d_pmem_resp, 1'b0);
    chkw("late_resp_i_rdata", i_pmem_rdata, '0);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    chk1("post_rst_no_read", mem_read, 1'b0);
    chk1("post_rst_no_write", mem_write, 1'b0);

    // Model restarts from reset: grant history back to D-cache
    owner = -1;
    cool  = 1'b0;
    last  = 1;
    cnt   = 0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    exp_mem.delete();
    exp_resp.delete();
    mon_en = 1'b1;

    run_random(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
